ipsxe_floating_point_group2_lo_carry_gen_v1_0: RTL and testbench
================================================================

Name: ipsxe_floating_point_group2_lo_carry_gen_v1_0

Overview:
- Producer side of the group2 segmented adder. It serially accumulates a burst of signed low-segment terms into a wide sum.
- Emits the 5-bit signed carry field (group2_lo_hi) and the low remainder.
- Emits a2_hi + cin1, computed once per burst.
- Outputs feed the group2_hi APM stage, which forms (a2_hi + cin1) + cin2.

Parameters:
- LO_W, 44, width of the low segment. The carry field sits directly above bit LO_W-1.
- HI_W, 8, width of the a2_hi segment and of its +cin1 result.
- CF_W, 5, width of the signed carry field. Fixed at 5; other values are not supported.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst_n  in  1  asynchronous reset, active-low.
- i_start  in  1  begin a burst. Sampled only in IDLE.
- i_num_terms  in  4  term count for the burst, 0..15. Sampled with i_start.
- i_a2_hi  in  HI_W  high segment. Sampled with i_start.
- i_cin1  in  1  carry into the high segment. Sampled with i_start.
- i_term_valid  in  1  i_term is valid this cycle. Honoured only in ACCUM.
- i_term  in  LO_W+1  signed two's-complement low-segment term.
- o_busy  out  1  high in ACCUM and DONE.
- o_valid  out  1  one-cycle pulse when the result is updated.
- o_group2_lo_hi  out  CF_W  signed carry field, equal to sum[LO_W+CF_W-1:LO_W].
- o_group2_lo  out  LO_W  low remainder, equal to sum[LO_W-1:0].
- o_a2_hi_plus_cin1  out  HI_W  (i_a2_hi + i_cin1) mod 2^HI_W.

Behaviour:
- Reset (async assert, sync release):
  - All outputs 0.
  - FSM enters IDLE.
  - Accumulator cleared to 0; term counter cleared to 0.
- Accumulator: signed, LO_W+CF_W bits wide.
  - Each accepted term is sign-extended from LO_W+1 bits and added.
  - Bounds: 15 terms minimum is -15*2^LO_W, maximum is 15*(2^LO_W-1). The sum can never overflow, so no saturation logic.
- FSM states:
  - IDLE:
    - On i_start: latch count; clear accumulator.
    - Register o_a2_hi_plus_cin1 <= i_a2_hi + i_cin1, wrapping 0xFF+1 -> 0x00.
    - Go to ACCUM if count != 0; go to DONE if count == 0.
    - Result update is deferred to DONE, so a zero-count burst yields sum 0.
  - ACCUM:
    - Each cycle with i_term_valid=1: accumulator += term; counter += 1.
    - When the counter reaches count on that cycle, go to DONE.
    - Cycles with i_term_valid=0 are stalls: no change. There is no timeout.
  - DONE (exactly 1 cycle):
    - Register o_group2_lo_hi and o_group2_lo from the accumulator.
    - Pulse o_valid=1.
    - Return to IDLE.
- Latency: the result is visible the cycle after DONE is entered, i.e. one cycle after the last accepted term (or two cycles after a zero-count i_start).
- o_a2_hi_plus_cin1 changes 1 cycle after an accepted i_start. It therefore leads o_valid.
- Outputs hold between bursts. o_valid is low except for the single pulse.
- i_start while busy is ignored; i_num_terms, i_a2_hi and i_cin1 are not resampled.
- i_term_valid in IDLE or DONE is ignored.
- i_start in the cycle DONE returns to IDLE is not accepted; it must be reasserted in IDLE.
- Reset mid-burst: immediate return to IDLE with outputs 0. No o_valid pulse. The partial sum is discarded.
- Carry-field encoding: the value as seen at the group2_hi X port is {3{cf[4]}, cf}, so downstream sign-extension is consistent.

Test Plan:
- Reset: hold i_rst_n=0 with i_start=1 -> all outputs 0, o_busy=0. Release; no o_valid until a full burst completes.
- Positive carry: start with num_terms=3, a2_hi=0x12, cin1=1; feed terms 2^LO_W-1 three times -> o_a2_hi_plus_cin1=0x13; sum = 3*2^LO_W - 3, so o_group2_lo_hi=5'b00010 and o_group2_lo = 2^LO_W - 3; o_valid pulses once.
- Negative carry plus stalls: num_terms=2, terms -2^LO_W and -1, with 2 idle cycles between them -> sum = -2^LO_W - 1, so o_group2_lo_hi=5'b11110 (-2), o_group2_lo = 2^LO_W-1; o_valid exactly 1 cycle after the 2nd term.
- Extremes: 15 terms of -2^LO_W -> o_group2_lo_hi=5'b10001 (-15), o_group2_lo=0. 15 terms of 2^LO_W-1 -> o_group2_lo_hi=14, o_group2_lo = 2^LO_W-15.
- Edge cases:
  - a2_hi=0xFF, cin1=1 -> o_a2_hi_plus_cin1=0x00.
  - num_terms=0 -> o_valid 2 cycles after i_start with o_group2_lo_hi=0 and o_group2_lo=0.
  - i_start pulsed during ACCUM -> ignored; the count is unchanged.
- Reset mid-burst: assert i_rst_n=0 after 1 of 4 terms -> outputs 0, FSM in IDLE, no o_valid. A new burst afterwards gives the correct fresh sum.

Source files
------------

// File: rtl/ipsxe_floating_point_group2_lo_carry_gen_v1_0.sv
// Low-segment carry producer for the group2 segmented adder: accumulates a burst of
// signed low terms, then publishes the signed carry field, low remainder and a2_hi+cin1.
module ipsxe_floating_point_group2_lo_carry_gen_v1_0 #(
    parameter int LO_W = 44,
    parameter int HI_W = 8,
    parameter int CF_W = 5
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic [3:0]             i_num_terms,
    input  logic [HI_W-1:0]        i_a2_hi,
    input  logic                   i_cin1,
    input  logic                   i_term_valid,
    input  logic signed [LO_W:0]   i_term,
    output logic                   o_busy,
    output logic                   o_valid,
    output logic [CF_W-1:0]        o_group2_lo_hi,
    output logic [LO_W-1:0]        o_group2_lo,
    output logic [HI_W-1:0]        o_a2_hi_plus_cin1
);

    localparam int ACC_W = LO_W + CF_W;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]               r_state;
    logic [3:0]               r_num;
    logic [3:0]               r_cnt;
    logic signed [ACC_W-1:0]  r_acc;
    logic                     r_valid;
    logic [CF_W-1:0]          r_cf;
    logic [LO_W-1:0]          r_lo;
    logic [HI_W-1:0]          r_a2p;

    logic signed [ACC_W-1:0]  w_term_ext;
    logic [3:0]               w_cnt_next;
    logic                     w_last;

    // 15 terms of at most |2^LO_W| fit in LO_W+CF_W signed bits, so plain wrap-free add.
    function automatic logic signed [ACC_W-1:0] sext_term(input logic signed [LO_W:0] t);
        return {{(CF_W-1){t[LO_W]}}, t};
    endfunction

    assign w_term_ext = sext_term(i_term);
    assign w_cnt_next = r_cnt + 4'd1;
    assign w_last     = (w_cnt_next == r_num);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
            r_num   <= '0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_valid <= 1'b0;
            r_cf    <= '0;
            r_lo    <= '0;
            r_a2p   <= '0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_num   <= i_num_terms;
                        r_cnt   <= '0;
                        r_acc   <= '0;
                        r_a2p   <= i_a2_hi + HI_W'(i_cin1);
                        r_state <= (i_num_terms == 4'd0) ? S_DONE : S_ACCUM;
                    end
                end
                S_ACCUM: begin
                    if (i_term_valid) begin
                        r_acc <= r_acc + w_term_ext;
                        r_cnt <= w_cnt_next;
                        if (w_last) r_state <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Publish only here so a zero-term burst reports the cleared sum.
                    r_cf    <= r_acc[ACC_W-1:LO_W];
                    r_lo    <= r_acc[LO_W-1:0];
                    r_valid <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_busy            = (r_state != S_IDLE);
    assign o_valid           = r_valid;
    assign o_group2_lo_hi    = r_cf;
    assign o_group2_lo       = r_lo;
    assign o_a2_hi_plus_cin1 = r_a2p;

endmodule

// File: tb/tb_ipsxe_floating_point_group2_lo_carry_gen_v1_0.sv
// Bench for the group2 low carry generator: directed scenarios plus random bursts
// compared against an arithmetic model of the burst sum.
module tb_ipsxe_floating_point_group2_lo_carry_gen_v1_0;

    logic               clk;
    logic               rst_n;
    logic               start;
    logic [3:0]         num;
    logic [7:0]         a2;
    logic               cin;
    logic               tv;
    logic signed [44:0] term;
    logic               busy;
    logic               valid;
    logic [4:0]         cf;
    logic [43:0]        lo;
    logic [7:0]         a2p;

    int    vectors = 0;
    int    miscompares = 0;
    int    vcount = 0;
    longint tq[$];

    logic [7:0]  d_a2_early;
    logic        d_busy_early;
    logic        d_vld_early;
    logic [4:0]  d_cf;
    logic [43:0] d_lo;
    logic [7:0]  d_a2_late;
    logic        d_vld_after;
    logic        d_busy_done;
    logic        d_busy_after;
    int          d_pulses;

    localparam longint P44 = 64'sd1 <<< 44;

    ipsxe_floating_point_group2_lo_carry_gen_v1_0 dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_num_terms(num),
        .i_a2_hi(a2), .i_cin1(cin), .i_term_valid(tv), .i_term(term),
        .o_busy(busy), .o_valid(valid), .o_group2_lo_hi(cf), .o_group2_lo(lo),
        .o_a2_hi_plus_cin1(a2p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) if (valid) vcount++;

    // Expected carry field / remainder: floor division of the plain integer sum by 2^44.
    task automatic model(output logic [4:0] ecf, output logic [43:0] elo);
        longint s = 0;
        longint c;
        foreach (tq[i]) s += tq[i];
        c   = s >>> 44;
        ecf = 5'(c);
        elo = 44'(s - (c <<< 44));
    endtask

    function automatic longint rand_term();
        logic signed [44:0] t;
        case ($urandom_range(0, 3))
            0:       t = 45'(-P44);
            1:       t = 45'(P44 - 1);
            default: t = 45'({$urandom, $urandom});
        endcase
        return longint'(t);
    endfunction

    // Drives one burst from tq; records observations for the calling test to judge.
    task automatic drive_burst(input int n, input logic [7:0] a2v, input logic cinv,
                               input int maxstall, input bit poke, input bit b2b);
        int p0 = vcount;
        @(negedge clk);
        start = 1'b1; num = 4'(n); a2 = a2v; cin = cinv;
        tv = poke; term = 45'({$urandom, $urandom});
        @(negedge clk);
        start = 1'b0; tv = 1'b0;
        d_a2_early = a2p; d_busy_early = busy;
        num = 4'($urandom); a2 = 8'($urandom); cin = 1'($urandom);
        for (int i = 0; i < n; i++) begin
            int k = $urandom_range(poke ? 1 : 0, maxstall);
            repeat (k) begin
                if (poke) begin start = 1'b1; num = 4'($urandom); a2 = 8'($urandom); end
                term = 45'({$urandom, $urandom});
                @(negedge clk);
                start = 1'b0;
            end
            term = 45'(tq[i]); tv = 1'b1;
            @(negedge clk);
            tv = 1'b0; term = 45'({$urandom, $urandom});
        end
        d_vld_early = valid;
        if (b2b) begin start = 1'b1; num = 4'd0; end
        @(negedge clk);
        start = 1'b0;
        d_cf = cf; d_lo = lo; d_a2_late = a2p; d_busy_done = busy;
        @(negedge clk);
        d_vld_after = valid; d_busy_after = busy;
        d_pulses = vcount - p0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; num = 4'd3; a2 = 8'h55; cin = 1'b1; tv = 1'b1; term = '1;
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, valid, cf, lo, a2p} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs got busy=%b vld=%b cf=%h lo=%h a2p=%h req all 0", busy, valid, cf, lo, a2p);
        end
        start = 1'b0; tv = 1'b0;
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        vectors++;
        if (vcount !== 0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_release got pulses=%0d busy=%b req 0/0", vcount, busy);
        end
    endtask

    task automatic test_pos_carry();
        tq = {P44 - 1, P44 - 1, P44 - 1};
        drive_burst(3, 8'h12, 1'b1, 0, 0, 0);
        vectors++;
        if (d_a2_early !== 8'h13) begin miscompares++; $display("FAIL pos_a2_early got %h req 13", d_a2_early); end
        vectors++;
        if (d_busy_early !== 1'b1) begin miscompares++; $display("FAIL pos_busy got %b req 1", d_busy_early); end
        vectors++;
        if (d_cf !== 5'b00010 || d_lo !== 44'(P44 - 3)) begin
            miscompares++; $display("FAIL pos_sum got cf=%b lo=%h req cf=00010 lo=%h", d_cf, d_lo, 44'(P44 - 3));
        end
        vectors++;
        if (d_pulses !== 1 || d_vld_early !== 1'b0 || d_vld_after !== 1'b0) begin
            miscompares++; $display("FAIL pos_pulse got pulses=%0d early=%b after=%b req 1/0/0", d_pulses, d_vld_early, d_vld_after);
        end
    endtask

    task automatic test_neg_carry_stalls();
        int p0;
        tq = {-P44, -64'sd1};
        p0 = vcount;
        @(negedge clk);
        start = 1'b1; num = 4'd2; a2 = 8'h00; cin = 1'b0;
        @(negedge clk);
        start = 1'b0; term = 45'(tq[0]); tv = 1'b1;
        @(negedge clk);
        tv = 1'b0;
        repeat (2) @(negedge clk);
        term = 45'(tq[1]); tv = 1'b1;
        @(negedge clk);
        tv = 1'b0;
        vectors++;
        if (valid !== 1'b0) begin miscompares++; $display("FAIL neg_early_valid got %b req 0", valid); end
        @(negedge clk);
        vectors++;
        if (valid !== 1'b1) begin miscompares++; $display("FAIL neg_valid_latency got %b req 1", valid); end
        vectors++;
        if (cf !== 5'b11110 || lo !== 44'(P44 - 1)) begin
            miscompares++; $display("FAIL neg_sum got cf=%b lo=%h req cf=11110 lo=%h", cf, lo, 44'(P44 - 1));
        end
        @(negedge clk);
        vectors++;
        if (vcount - p0 !== 1 || valid !== 1'b0) begin
            miscompares++; $display("FAIL neg_pulse got pulses=%0d vld=%b req 1/0", vcount - p0, valid);
        end
    endtask

    task automatic test_extremes();
        tq = {};
        repeat (15) tq.push_back(-P44);
        drive_burst(15, 8'h40, 1'b0, 1, 0, 0);
        vectors++;
        if (d_cf !== 5'b10001 || d_lo !== 44'd0) begin
            miscompares++; $display("FAIL ext_min got cf=%b lo=%h req cf=10001 lo=0", d_cf, d_lo);
        end
        tq = {};
        repeat (15) tq.push_back(P44 - 1);
        drive_burst(15, 8'h41, 1'b0, 1, 0, 0);
        vectors++;
        if (d_cf !== 5'd14 || d_lo !== 44'(P44 - 15)) begin
            miscompares++; $display("FAIL ext_max got cf=%0d lo=%h req cf=14 lo=%h", d_cf, d_lo, 44'(P44 - 15));
        end
    endtask

    task automatic test_a2_wrap();
        tq = {64'sd7};
        drive_burst(1, 8'hFF, 1'b1, 0, 0, 0);
        vectors++;
        if (d_a2_early !== 8'h00 || d_a2_late !== 8'h00) begin
            miscompares++; $display("FAIL a2_wrap got early=%h late=%h req 00", d_a2_early, d_a2_late);
        end
    endtask

    task automatic test_zero_count();
        tq = {};
        drive_burst(0, 8'h20, 1'b0, 0, 0, 0);
        vectors++;
        if (d_cf !== 5'd0 || d_lo !== 44'd0 || d_pulses !== 1) begin
            miscompares++; $display("FAIL zero_count got cf=%h lo=%h pulses=%0d req 0/0/1", d_cf, d_lo, d_pulses);
        end
        vectors++;
        if (d_vld_early !== 1'b0 || d_busy_early !== 1'b1 || d_a2_early !== 8'h20) begin
            miscompares++; $display("FAIL zero_timing got vld=%b busy=%b a2=%h req 0/1/20", d_vld_early, d_busy_early, d_a2_early);
        end
    endtask

    task automatic test_start_ignored();
        logic [4:0] ecf;
        logic [43:0] elo;
        tq = {};
        repeat (5) tq.push_back(rand_term());
        model(ecf, elo);
        drive_burst(5, 8'h3C, 1'b1, 3, 1, 0);
        vectors++;
        if (d_cf !== ecf || d_lo !== elo || d_pulses !== 1 || d_a2_late !== 8'h3D) begin
            miscompares++;
            $display("FAIL start_ignored got cf=%h lo=%h pulses=%0d a2=%h req cf=%h lo=%h 1 3d", d_cf, d_lo, d_pulses, d_a2_late, ecf, elo);
        end
    endtask

    task automatic test_back_to_back();
        tq = {64'sd1, 64'sd2};
        drive_burst(2, 8'h01, 1'b0, 0, 0, 1);
        vectors++;
        if (d_busy_done !== 1'b0 || d_busy_after !== 1'b0 || d_pulses !== 1) begin
            miscompares++; $display("FAIL b2b_start_in_done got busy=%b/%b pulses=%0d req 0/0/1", d_busy_done, d_busy_after, d_pulses);
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [4:0] ecf;
        logic [43:0] elo;
        int p0;
        tq = {64'sd5, 64'sd6, 64'sd7, 64'sd8};
        p0 = vcount;
        @(negedge clk);
        start = 1'b1; num = 4'd4; a2 = 8'h77; cin = 1'b0;
        @(negedge clk);
        start = 1'b0; term = 45'(tq[0]); tv = 1'b1;
        @(negedge clk);
        tv = 1'b0;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({busy, valid, cf, lo, a2p} !== '0) begin
            miscompares++; $display("FAIL midrst_outputs got busy=%b vld=%b cf=%h lo=%h a2p=%h req 0", busy, valid, cf, lo, a2p);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        vectors++;
        if (vcount !== p0 || busy !== 1'b0) begin
            miscompares++; $display("FAIL midrst_no_valid got pulses=%0d busy=%b req 0/0", vcount - p0, busy);
        end
        tq = {64'sd100, -64'sd300, P44 - 1};
        model(ecf, elo);
        drive_burst(3, 8'h09, 1'b1, 2, 0, 0);
        vectors++;
        if (d_cf !== ecf || d_lo !== elo || d_a2_late !== 8'h0A) begin
            miscompares++; $display("FAIL midrst_fresh got cf=%h lo=%h a2=%h req cf=%h lo=%h a2=0a", d_cf, d_lo, d_a2_late, ecf, elo);
        end
    endtask

    task automatic test_random();
        logic [4:0] ecf;
        logic [43:0] elo;
        logic [7:0] ea2;
        for (int b = 0; b < 30; b++) begin
            int n = $urandom_range(0, 15);
            logic [7:0] av = 8'($urandom);
            logic cv = 1'($urandom);
            tq = {};
            for (int i = 0; i < n; i++) tq.push_back(rand_term());
            model(ecf, elo);
            ea2 = 8'((int'(av) + int'(cv)) % 256);
            drive_burst(n, av, cv, 2, $urandom_range(0, 1) == 1, 0);
            vectors++;
            if (d_cf !== ecf || d_lo !== elo || d_a2_late !== ea2 || d_pulses !== 1) begin
                miscompares++;
                $display("FAIL random_%0d n=%0d got cf=%h lo=%h a2=%h pulses=%0d req cf=%h lo=%h a2=%h 1",
                         b, n, d_cf, d_lo, d_a2_late, d_pulses, ecf, elo, ea2);
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; num = '0; a2 = '0; cin = 1'b0; tv = 1'b0; term = '0;
        test_reset();
        test_pos_carry();
        test_neg_carry_stalls();
        test_extremes();
        test_a2_wrap();
        test_zero_count();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
